tea_cipher_core: RTL and testbench

Iterative, parametrised TEA block cipher engine supporting encryption and decryption, selected per block. It replaces the fixed 64-stage, encrypt-only pipeline with a folded datapath that computes UNROLL full rounds per clock, trading area for latency. The core sits behind the AXI-Stream TEA wrapper. It uses valid/ready handshakes on both sides with full output backpressure.

---
 rtl/tea_pkg.sv | 39 +++
 rtl/tea_round.sv | 49 ++++
 rtl/tea_cipher_core.sv | 188 ++++++++++++++++++
 tb/tb_tea_cipher_core.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// ---------------------------------------------------------------------------
// tea_pkg
//   Shared definitions for the folded TEA cipher core.
//   - TEA_DELTA      : key-schedule constant.
//   - tea_state_e    : controller states (IDLE / RUN / DONE).
//   - KEY_K0..KEY_K3 : 32-bit word indices into the 128-bit key.
//   - key_word()     : extracts one 32-bit key word.
//   - tea_mix()      : the ((v<<4)+ka) ^ (v+sum) ^ ((v>>5)+kb) term shared by
//                      both half-rounds in both directions.
// ---------------------------------------------------------------------------
package tea_pkg;

    localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tea_state_e;

    localparam int KEY_K0 = 0;
    localparam int KEY_K1 = 1;
    localparam int KEY_K2 = 2;
    localparam int KEY_K3 = 3;

    function automatic logic [31:0] key_word(input logic [127:0] key, input int idx);
        return key[idx*32 +: 32];
    endfunction

    function automatic logic [31:0] tea_mix(
        input logic [31:0] v,
        input logic [31:0] sum,
        input logic [31:0] ka,
        input logic [31:0] kb
    );
        return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
    endfunction

endpackage

// File: rtl/tea_round.sv
// ---------------------------------------------------------------------------
// tea_round
//   One full TEA round (two half-rounds plus the sum update), purely
//   combinational. mode=0 encrypts, mode=1 decrypts. The round uses the
//   incoming sum and hands the advanced sum to the next round in the chain.
//
//   Ports:
//     y_i, z_i, sum_i : 32-bit state entering the round
//     key             : 128-bit key, k0 in bits [31:0]
//     mode            : 0 = encrypt, 1 = decrypt
//     y_o, z_o, sum_o : 32-bit state leaving the round
// ---------------------------------------------------------------------------
module tea_round
    import tea_pkg::*;
#(
    parameter logic [31:0] DELTA = TEA_DELTA
) (
    input  logic [31:0]  y_i,
    input  logic [31:0]  z_i,
    input  logic [31:0]  sum_i,
    input  logic [127:0] key,
    input  logic         mode,
    output logic [31:0]  y_o,
    output logic [31:0]  z_o,
    output logic [31:0]  sum_o
);

    logic [31:0] k0, k1, k2, k3;

    assign k0 = key_word(key, KEY_K0);
    assign k1 = key_word(key, KEY_K1);
    assign k2 = key_word(key, KEY_K2);
    assign k3 = key_word(key, KEY_K3);

    // The second half-round consumes the value the first half-round just
    // produced, so the order inside each branch matters.
    always_comb begin
        if (!mode) begin
            y_o   = y_i + tea_mix(z_i, sum_i, k0, k1);
            z_o   = z_i + tea_mix(y_o, sum_i, k2, k3);
            sum_o = sum_i + DELTA;
        end else begin
            z_o   = z_i - tea_mix(y_i, sum_i, k2, k3);
            y_o   = y_i - tea_mix(z_o, sum_i, k0, k1);
            sum_o = sum_i - DELTA;
        end
    end

endmodule

// File: rtl/tea_cipher_core.sv
// ---------------------------------------------------------------------------
// tea_cipher_core
//   Folded TEA block cipher engine. Each clock in RUN applies UNROLL chained
//   rounds, so a block needs N = ROUNDS/UNROLL clocks. Encrypt or decrypt is
//   chosen per block at accept time. Valid/ready on both sides, with full
//   output backpressure and a same-edge handoff from DONE to the next block.
//
//   Parameters:
//     DELTA  : key-schedule constant
//     ROUNDS : full rounds per block (even, 2..64)
//     UNROLL : rounds per clock, must divide ROUNDS
//
//   Ports:
//     clk, resetn          : clock, asynchronous active-low reset
//     key[127:0]           : k0=[31:0] .. k3=[127:96], sampled at accept
//     in_data[63:0]        : y=[31:0], z=[63:32]
//     in_mode              : 0=encrypt, 1=decrypt, sampled at accept
//     in_valid / in_ready  : input handshake
//     out_data[63:0]       : {z, y} result
//     out_mode             : mode the result was produced with
//     out_valid / out_ready: output handshake
// ---------------------------------------------------------------------------
module tea_cipher_core
    import tea_pkg::*;
#(
    parameter logic [31:0] DELTA  = TEA_DELTA,
    parameter int          ROUNDS = 32,
    parameter int          UNROLL = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [127:0] key,
    input  logic [63:0]  in_data,
    input  logic         in_mode,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [63:0]  out_data,
    output logic         out_mode,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int                N        = ROUNDS / UNROLL;
    localparam int                CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);
    // Decryption walks the schedule backwards from the last encrypt sum.
    localparam logic [31:0]       SUM_DEC  = DELTA * 32'(ROUNDS);

    generate
        if (UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
            $error("tea_cipher_core: UNROLL must be >= 1 and divide ROUNDS");
        end
        if (ROUNDS < 2 || ROUNDS > 64 || (ROUNDS % 2) != 0) begin : g_bad_rounds
            $error("tea_cipher_core: ROUNDS must be even and within 2..64");
        end
    endgenerate

    tea_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      y_q, y_d;
    logic [31:0]      z_q, z_d;
    logic [31:0]      sum_q, sum_d;
    logic [127:0]     key_q, key_d;
    logic             mode_q, mode_d;
    logic [63:0]      out_data_q, out_data_d;
    logic             out_mode_q, out_mode_d;

    logic             accept;

    // ------------------------------------------------------------------
    // Round chain: UNROLL rounds between the state registers.
    // ------------------------------------------------------------------
    logic [31:0] y_chain   [UNROLL+1];
    logic [31:0] z_chain   [UNROLL+1];
    logic [31:0] sum_chain [UNROLL+1];

    assign y_chain[0]   = y_q;
    assign z_chain[0]   = z_q;
    assign sum_chain[0] = sum_q;

    for (genvar r = 0; r < UNROLL; r++) begin : g_round
        tea_round #(
            .DELTA (DELTA)
        ) u_round (
            .y_i   (y_chain[r]),
            .z_i   (z_chain[r]),
            .sum_i (sum_chain[r]),
            .key   (key_q),
            .mode  (mode_q),
            .y_o   (y_chain[r+1]),
            .z_o   (z_chain[r+1]),
            .sum_o (sum_chain[r+1])
        );
    end

    // ------------------------------------------------------------------
    // State register (and all other flops)
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            y_q        <= '0;
            z_q        <= '0;
            sum_q      <= '0;
            key_q      <= '0;
            mode_q     <= 1'b0;
            out_data_q <= '0;
            out_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            y_q        <= y_d;
            z_q        <= z_d;
            sum_q      <= sum_d;
            key_q      <= key_d;
            mode_q     <= mode_d;
            out_data_q <= out_data_d;
            out_mode_q <= out_mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Output logic. in_ready is combinational from out_ready so DONE can
    // hand off to the next block on the same edge it drains the result.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
    end

    assign out_data = out_data_q;
    assign out_mode = out_mode_q;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven in an always_comb gets a default on entry,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (cnt_q == '0) state_d = DONE;
            DONE: if (out_ready) state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        y_d        = y_q;
        z_d        = z_q;
        sum_d      = sum_q;
        key_d      = key_q;
        mode_d     = mode_q;
        out_data_d = out_data_q;
        out_mode_d = out_mode_q;

        if (accept) begin
            y_d    = in_data[31:0];
            z_d    = in_data[63:32];
            key_d  = key;
            mode_d = in_mode;
            sum_d  = in_mode ? SUM_DEC : DELTA;
            cnt_d  = CNT_LAST;
        end else if (state_q == RUN) begin
            y_d   = y_chain[UNROLL];
            z_d   = z_chain[UNROLL];
            sum_d = sum_chain[UNROLL];
            if (cnt_q == '0) begin
                // Result registers are separate from y/z so the last result
                // survives the next accept until a new one completes.
                out_data_d = {z_chain[UNROLL], y_chain[UNROLL]};
                out_mode_d = mode_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tea_cipher_core.sv
// ---------------------------------------------------------------------------
// tb_tea_cipher_core
//   Four cores (UNROLL = 1, 2, 4, 8; ROUNDS = 32) each run the same program
//   on their own handshake and reset. A per-core monitor predicts
//   out_valid/in_ready/out_data/out_mode every cycle from a plain C-style TEA
//   reference and the accept timestamps; the driver adds literal and
//   round-trip checks.
// ---------------------------------------------------------------------------
module tb_tea_cipher_core;

    localparam int          ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;
    localparam int          RT     = 200;
    localparam logic [63:0] ZERO_VEC_CT = 64'h94BAA940_41EA3A0A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input int u, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL u%0d %s: got 0x%h expected 0x%h at %0t", u, name, act, exp, $time);
        end
    endtask

    // Reference TEA in the usual textbook form: sum advanced before use.
    function automatic logic [63:0] tea_ref(input logic [127:0] k,
                                            input logic [63:0] d,
                                            input logic dec);
        logic [31:0] y, z, s, k0, k1, k2, k3;
        {k3, k2, k1, k0} = k;
        y = d[31:0];
        z = d[63:32];
        if (!dec) begin
            s = 32'd0;
            for (int r = 0; r < ROUNDS; r++) begin
                s += DELTA;
                y += ((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1);
                z += ((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3);
            end
        end else begin
            s = DELTA * 32'(ROUNDS);
            for (int r = 0; r < ROUNDS; r++) begin
                z -= ((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3);
                y -= ((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1);
                s -= DELTA;
            end
        end
        return {z, y};
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_inst
        localparam int U = 1 << g;
        localparam int N = ROUNDS / U;

        logic         resetn;
        logic [127:0] key;
        logic [63:0]  in_data;
        logic         in_mode;
        logic         in_valid;
        logic         in_ready;
        logic [63:0]  out_data;
        logic         out_mode;
        logic         out_valid;
        logic         out_ready;

        logic [64:0]  exp_q [$];
        int           acc_q [$];
        int           cyc;
        bit           done = 1'b0;

        tea_cipher_core #(
            .DELTA  (DELTA),
            .ROUNDS (ROUNDS),
            .UNROLL (U)
        ) u_dut (
            .clk       (clk),
            .resetn    (resetn),
            .key       (key),
            .in_data   (in_data),
            .in_mode   (in_mode),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .out_data  (out_data),
            .out_mode  (out_mode),
            .out_valid (out_valid),
            .out_ready (out_ready)
        );

        // Offer a block from just after a posedge until it is accepted.
        task automatic send(input logic [127:0] k, input logic [63:0] d, input logic m);
            bit acc;
            acc      = 1'b0;
            key      = k;
            in_data  = d;
            in_mode  = m;
            in_valid = 1'b1;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            check(U, "send_accepted", 64'(acc), 64'd1);
        endtask

        // Wait for a result with out_ready high; lat counts idle cycles.
        task automatic recv(output logic [63:0] d, output logic m, output int lat);
            bit got;
            got       = 1'b0;
            lat       = 0;
            d         = '0;
            m         = 1'b0;
            out_ready = 1'b1;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge clk);
                if (out_valid) begin
                    got = 1'b1;
                    d   = out_data;
                    m   = out_mode;
                end else begin
                    lat++;
                end
                @(posedge clk);
                #1;
            end
            out_ready = 1'b0;
            check(U, "recv_valid", 64'(got), 64'd1);
        endtask

        // Cycle-by-cycle monitor: one block in flight; out_valid is expected
        // from N+1 sampling cycles after the accept until it is taken.
        initial begin : monitor
            bit exp_v;
            cyc = 0;
            forever begin
                @(negedge clk);
                cyc++;
                if (!resetn) begin
                    exp_q.delete();
                    acc_q.delete();
                    check(U, "rst_out_valid", 64'(out_valid), 64'd0);
                    check(U, "rst_in_ready",  64'(in_ready),  64'd1);
                    check(U, "rst_out_data",  out_data,       64'd0);
                    check(U, "rst_out_mode",  64'(out_mode),  64'd0);
                end else begin
                    exp_v = (exp_q.size() > 0) && (cyc - acc_q[0] >= N + 1);
                    check(U, "out_valid", 64'(out_valid), 64'(exp_v));
                    check(U, "in_ready", 64'(in_ready),
                          64'((exp_q.size() == 0) || (exp_v && out_ready)));
                    if (exp_v && out_valid) begin
                        check(U, "out_data", out_data, exp_q[0][63:0]);
                        check(U, "out_mode", 64'(out_mode), 64'(exp_q[0][64]));
                    end
                    if (exp_v && out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                    if (in_valid && in_ready) begin
                        exp_q.push_back({in_mode, tea_ref(key, in_data, in_mode)});
                        acc_q.push_back(cyc);
                    end
                end
            end
        end

        initial begin : driver
            logic [127:0] k, k2;
            logic [63:0]  d, d2, c, p, first;
            logic         m;
            int           lat, t;
            bit           acc;

            resetn    = 1'b0;
            key       = '0;
            in_data   = '0;
            in_mode   = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 resetn = 1'b1;
            @(posedge clk);
            #1;

            // Known vector and latency; result held after drain.
            send('0, '0, 1'b0);
            recv(c, m, lat);
            check(U, "vec_data", c, ZERO_VEC_CT);
            check(U, "vec_mode", 64'(m), 64'd0);
            check(U, "vec_latency", 64'(lat), 64'(N));
            repeat (3) @(posedge clk);
            @(negedge clk);
            check(U, "hold_after_drain", out_data, ZERO_VEC_CT);
            @(posedge clk);
            #1;

            // Backpressure, then same-edge handoff.
            k = rand128();
            d = rand64();
            send(k, d, 1'b0);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!out_valid && t < 200);
            check(U, "bp_valid_seen", 64'(out_valid), 64'd1);
            first = out_data;
            check(U, "bp_first_data", first, tea_ref(k, d, 1'b0));
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check(U, "bp_stable", out_data, first);
                check(U, "bp_in_ready_low", 64'(in_ready), 64'd0);
            end
            @(posedge clk);
            #1;
            k2        = rand128();
            d2        = rand64();
            key       = k2;
            in_data   = d2;
            in_mode   = 1'b1;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            check(U, "bp_handoff_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            recv(c, m, lat);
            check(U, "bp_next_latency", 64'(lat), 64'(N));
            check(U, "bp_next_data", c, tea_ref(k2, d2, 1'b1));
            check(U, "bp_next_mode", 64'(m), 64'd1);

            // Streaming with both valid and ready held high.
            out_ready = 1'b1;
            in_valid  = 1'b1;
            for (int j = 0; j < 6; j++) begin
                key     = rand128();
                in_data = rand64();
                in_mode = 1'($urandom_range(0, 1));
                t   = 0;
                acc = 1'b0;
                while (!acc && t < 200) begin
                    @(negedge clk);
                    t++;
                    acc = in_ready;
                    @(posedge clk);
                    #1;
                end
                check(U, "stream_accept", 64'(acc), 64'd1);
                if (j > 0) check(U, "stream_period", 64'(t), 64'(N + 1));
            end
            in_valid = 1'b0;
            repeat (N + 3) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            check(U, "stream_drained", 64'(exp_q.size()), 64'd0);
            @(posedge clk);
            #1;

            // Key and mode wiggle while the block is in flight.
            k = rand128();
            d = rand64();
            send(k, d, 1'b1);
            repeat (2) begin
                key     = rand128();
                in_mode = ~in_mode;
                in_data = rand64();
                @(posedge clk);
                #1;
            end
            recv(c, m, lat);
            check(U, "midrun_data", c, tea_ref(k, d, 1'b1));
            check(U, "midrun_mode", 64'(m), 64'd1);

            // Reset in the middle of RUN aborts the block.
            k = rand128();
            d = rand64();
            send(k, d, 1'b0);
            repeat (3) @(posedge clk);
            #1 resetn = 1'b0;
            @(negedge clk);
            check(U, "abort_out_valid", 64'(out_valid), 64'd0);
            check(U, "abort_in_ready", 64'(in_ready), 64'd1);
            check(U, "abort_out_data", out_data, 64'd0);
            @(posedge clk);
            #1 resetn = 1'b1;
            repeat (N + 2) @(negedge clk);
            check(U, "abort_no_output", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
            k2 = rand128();
            d2 = rand64();
            send(k2, d2, 1'b0);
            recv(c, m, lat);
            check(U, "post_reset_data", c, tea_ref(k2, d2, 1'b0));
            check(U, "post_reset_latency", 64'(lat), 64'(N));

            // Random round trips.
            for (int i = 0; i < RT; i++) begin
                k = rand128();
                d = rand64();
                send(k, d, 1'b0);
                recv(c, m, lat);
                check(U, "rt_enc_mode", 64'(m), 64'd0);
                send(k, c, 1'b1);
                recv(p, m, lat);
                check(U, "rt_plain", p, d);
                check(U, "rt_dec_mode", 64'(m), 64'd1);
            end

            done = 1'b1;
        end
    end

    initial begin : control
        bit all_done;
        check(0, "model_zero_vec", tea_ref('0, '0, 1'b0), ZERO_VEC_CT);
        check(0, "model_inverse", tea_ref('0, ZERO_VEC_CT, 1'b1), 64'd0);
        fork
            wait (g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done);
            #600000;
        join_any
        disable fork;
        all_done = g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done;
        check(0, "all_instances_done", 64'(all_done), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
